// File: rtl/z80fi_insn_recorder.sv
// z80fi retirement-packet recorder: splits per-clock core activity at M1 boundaries into one packet per instruction.
// Optional first-read capture is enabled by defining Z80FI_RECORD_MEM_RD_EN.

`ifndef CYCLE_NONE
`define CYCLE_NONE     3'd0
`define CYCLE_M1       3'd1
`define CYCLE_RD_MEM   3'd2
`define CYCLE_WR_MEM   3'd3
`define CYCLE_RDWR_MEM 3'd4
`define CYCLE_RD_IO    3'd5
`define CYCLE_WR_IO    3'd6
`define CYCLE_INTERNAL 3'd7
`endif

module z80fi_insn_recorder #(
   parameter int unsigned TCYC_W = 5,
   parameter int unsigned REGS_W = 128
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_m1_start,
   input  logic              cpu_mcycle_start,
   input  logic [2:0]        cpu_mcycle_type,
   input  logic              cpu_fetch_valid,
   input  logic [7:0]        cpu_fetch_data,
   input  logic              cpu_mem_wr,
   input  logic [15:0]       cpu_mem_waddr,
   input  logic [7:0]        cpu_mem_wdata,
   input  logic [REGS_W-1:0] cpu_regs,
`ifdef Z80FI_RECORD_MEM_RD_EN
   input  logic              cpu_mem_rd,
   input  logic [15:0]       cpu_mem_raddr,
   input  logic [7:0]        cpu_mem_rdata,
   output logic              z80fi_mem_rd,
   output logic [15:0]       z80fi_bus_raddr,
   output logic [7:0]        z80fi_bus_rdata,
`endif
   output logic              z80fi_valid,
   output logic [31:0]       z80fi_insn,
   output logic [2:0]        z80fi_insn_len,
   output logic [REGS_W-1:0] z80fi_regs_in,
   output logic [REGS_W-1:0] z80fi_regs_out,
   output logic              z80fi_mem_wr,
   output logic [15:0]       z80fi_bus_waddr,
   output logic [7:0]        z80fi_bus_wdata,
   output logic [2:0]        z80fi_mcycle_type1,
   output logic [2:0]        z80fi_mcycle_type2,
   output logic [2:0]        z80fi_mcycle_type3,
   output logic [TCYC_W-1:0] z80fi_tcycles1,
   output logic [TCYC_W-1:0] z80fi_tcycles2,
   output logic [TCYC_W-1:0] z80fi_tcycles3,
   output logic              z80fi_overflow
);

   localparam int unsigned NMC = 3;
   localparam logic [TCYC_W-1:0] TC_MAX = '1;

   typedef enum logic {IDLE, RUN} state_t;
   state_t state;

   // Accumulators for the instruction currently executing
   logic [31:0]       acc_insn,  b_insn,  n_insn;
   logic [2:0]        acc_len,   b_len,   n_len;
   logic [2:0]        acc_idx,   b_idx,   n_idx;
   logic [2:0]        acc_type [NMC];
   logic [2:0]        b_type   [NMC];
   logic [2:0]        n_type   [NMC];
   logic [TCYC_W-1:0] acc_tc   [NMC];
   logic [TCYC_W-1:0] b_tc     [NMC];
   logic [TCYC_W-1:0] n_tc     [NMC];
   logic              acc_wr,    b_wr,    n_wr;
   logic [15:0]       acc_waddr, b_waddr, n_waddr;
   logic [7:0]        acc_wdata, b_wdata, n_wdata;
   logic              acc_ovf,   b_ovf,   n_ovf;
   logic [REGS_W-1:0] acc_regs_in;
   logic              mc_start;
`ifdef Z80FI_RECORD_MEM_RD_EN
   logic              acc_rd,    b_rd,    n_rd;
   logic [15:0]       acc_raddr, b_raddr, n_raddr;
   logic [7:0]        acc_rdata, b_rdata, n_rdata;
`endif

   // M1 start also opens M-cycle 1, even if the core omits the mcycle strobe
   assign mc_start = cpu_mcycle_start | cpu_m1_start;

   // Next accumulator state: restart on M1, then fold in this clock's events
   always_comb begin
      b_insn  = acc_insn;
      b_len   = acc_len;
      b_idx   = acc_idx;
      b_type  = acc_type;
      b_tc    = acc_tc;
      b_wr    = acc_wr;
      b_waddr = acc_waddr;
      b_wdata = acc_wdata;
      b_ovf   = acc_ovf;
`ifdef Z80FI_RECORD_MEM_RD_EN
      b_rd    = acc_rd;
      b_raddr = acc_raddr;
      b_rdata = acc_rdata;
`endif
      if (cpu_m1_start) begin
         b_insn  = '0;
         b_len   = '0;
         b_idx   = '0;
         for (int i = 0; i < NMC; i++) begin
            b_type[i] = `CYCLE_NONE;
            b_tc[i]   = '0;
         end
         b_wr    = 1'b0;
         b_waddr = '0;
         b_wdata = '0;
         b_ovf   = 1'b0;
`ifdef Z80FI_RECORD_MEM_RD_EN
         b_rd    = 1'b0;
         b_raddr = '0;
         b_rdata = '0;
`endif
      end

      n_insn  = b_insn;
      n_len   = b_len;
      n_idx   = b_idx;
      n_type  = b_type;
      n_tc    = b_tc;
      n_wr    = b_wr;
      n_waddr = b_waddr;
      n_wdata = b_wdata;
      n_ovf   = b_ovf;
`ifdef Z80FI_RECORD_MEM_RD_EN
      n_rd    = b_rd;
      n_raddr = b_raddr;
      n_rdata = b_rdata;
`endif

      if (cpu_fetch_valid) begin
         if (b_len < 3'd4) begin
            for (int i = 0; i < 4; i++)
               if (b_len == 3'(i)) n_insn[8*i +: 8] = cpu_fetch_data;
            n_len = b_len + 3'd1;
         end else begin
            n_ovf = 1'b1;
         end
      end

      // Index 4 means "past the recorded M-cycles"; nothing further is counted
      if (mc_start) begin
         if (b_idx < 3'(NMC)) begin
            n_idx = b_idx + 3'd1;
         end else begin
            n_idx = 3'(NMC + 1);
            n_ovf = 1'b1;
         end
      end

      for (int i = 0; i < NMC; i++) begin
         if (n_idx == 3'(i + 1)) begin
            if (mc_start) n_type[i] = cpu_mcycle_type;
            if (b_tc[i] == TC_MAX) n_ovf = 1'b1;
            else                   n_tc[i] = b_tc[i] + TCYC_W'(1);
         end
      end

      if (cpu_mem_wr) begin
         if (!b_wr) begin
            n_wr    = 1'b1;
            n_waddr = cpu_mem_waddr;
            n_wdata = cpu_mem_wdata;
         end else begin
            n_ovf = 1'b1;
         end
      end

`ifdef Z80FI_RECORD_MEM_RD_EN
      if (cpu_mem_rd && !cpu_fetch_valid) begin
         if (!b_rd) begin
            n_rd    = 1'b1;
            n_raddr = cpu_mem_raddr;
            n_rdata = cpu_mem_rdata;
         end else begin
            n_ovf = 1'b1;
         end
      end
`endif
   end

   // FSM, accumulator registers and packet emission
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state              <= IDLE;
         acc_insn           <= '0;
         acc_len            <= '0;
         acc_idx            <= '0;
         for (int i = 0; i < NMC; i++) begin
            acc_type[i] <= `CYCLE_NONE;
            acc_tc[i]   <= '0;
         end
         acc_wr             <= 1'b0;
         acc_waddr          <= '0;
         acc_wdata          <= '0;
         acc_ovf            <= 1'b0;
         acc_regs_in        <= '0;
         z80fi_valid        <= 1'b0;
         z80fi_insn         <= '0;
         z80fi_insn_len     <= '0;
         z80fi_regs_in      <= '0;
         z80fi_regs_out     <= '0;
         z80fi_mem_wr       <= 1'b0;
         z80fi_bus_waddr    <= '0;
         z80fi_bus_wdata    <= '0;
         z80fi_mcycle_type1 <= `CYCLE_NONE;
         z80fi_mcycle_type2 <= `CYCLE_NONE;
         z80fi_mcycle_type3 <= `CYCLE_NONE;
         z80fi_tcycles1     <= '0;
         z80fi_tcycles2     <= '0;
         z80fi_tcycles3     <= '0;
         z80fi_overflow     <= 1'b0;
`ifdef Z80FI_RECORD_MEM_RD_EN
         acc_rd             <= 1'b0;
         acc_raddr          <= '0;
         acc_rdata          <= '0;
         z80fi_mem_rd       <= 1'b0;
         z80fi_bus_raddr    <= '0;
         z80fi_bus_rdata    <= '0;
`endif
      end else begin
         z80fi_valid <= 1'b0;
         if (cpu_m1_start || state == RUN) begin
            acc_insn  <= n_insn;
            acc_len   <= n_len;
            acc_idx   <= n_idx;
            acc_type  <= n_type;
            acc_tc    <= n_tc;
            acc_wr    <= n_wr;
            acc_waddr <= n_waddr;
            acc_wdata <= n_wdata;
            acc_ovf   <= n_ovf;
`ifdef Z80FI_RECORD_MEM_RD_EN
            acc_rd    <= n_rd;
            acc_raddr <= n_raddr;
            acc_rdata <= n_rdata;
`endif
         end
         if (cpu_m1_start) begin
            state       <= RUN;
            acc_regs_in <= cpu_regs;
            if (state == RUN) begin
               z80fi_valid        <= 1'b1;
               z80fi_insn         <= acc_insn;
               z80fi_insn_len     <= acc_len;
               z80fi_regs_in      <= acc_regs_in;
               z80fi_regs_out     <= cpu_regs;
               z80fi_mem_wr       <= acc_wr;
               z80fi_bus_waddr    <= acc_waddr;
               z80fi_bus_wdata    <= acc_wdata;
               z80fi_mcycle_type1 <= acc_type[0];
               z80fi_mcycle_type2 <= acc_type[1];
               z80fi_mcycle_type3 <= acc_type[2];
               z80fi_tcycles1     <= acc_tc[0];
               z80fi_tcycles2     <= acc_tc[1];
               z80fi_tcycles3     <= acc_tc[2];
               z80fi_overflow     <= acc_ovf;
`ifdef Z80FI_RECORD_MEM_RD_EN
               z80fi_mem_rd       <= acc_rd;
               z80fi_bus_raddr    <= acc_raddr;
               z80fi_bus_rdata    <= acc_rdata;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_z80fi_insn_recorder.sv
// Directed bench for z80fi_insn_recorder: expected packets are queued as each
// instruction is closed and compared when the recorder strobes z80fi_valid.

`ifndef CYCLE_NONE
`define CYCLE_NONE     3'd0
`define CYCLE_M1       3'd1
`define CYCLE_RD_MEM   3'd2
`define CYCLE_WR_MEM   3'd3
`define CYCLE_RDWR_MEM 3'd4
`define CYCLE_RD_IO    3'd5
`define CYCLE_WR_IO    3'd6
`define CYCLE_INTERNAL 3'd7
`endif

module tb_z80fi_insn_recorder;

   localparam int unsigned TCYC_W = 5;
   localparam int unsigned REGS_W = 128;

   logic              clk = 1'b0;
   logic              reset;
   logic              cpu_m1_start, cpu_mcycle_start, cpu_fetch_valid, cpu_mem_wr;
   logic [2:0]        cpu_mcycle_type;
   logic [7:0]        cpu_fetch_data, cpu_mem_wdata;
   logic [15:0]       cpu_mem_waddr;
   logic [REGS_W-1:0] cpu_regs;
   logic              z80fi_valid, z80fi_mem_wr, z80fi_overflow;
   logic [31:0]       z80fi_insn;
   logic [2:0]        z80fi_insn_len;
   logic [REGS_W-1:0] z80fi_regs_in, z80fi_regs_out;
   logic [15:0]       z80fi_bus_waddr;
   logic [7:0]        z80fi_bus_wdata;
   logic [2:0]        z80fi_mcycle_type1, z80fi_mcycle_type2, z80fi_mcycle_type3;
   logic [TCYC_W-1:0] z80fi_tcycles1, z80fi_tcycles2, z80fi_tcycles3;
`ifdef Z80FI_RECORD_MEM_RD_EN
   logic              cpu_mem_rd = 1'b0;
   logic [15:0]       cpu_mem_raddr = '0;
   logic [7:0]        cpu_mem_rdata = '0;
   logic              z80fi_mem_rd;
   logic [15:0]       z80fi_bus_raddr;
   logic [7:0]        z80fi_bus_rdata;
`endif

   z80fi_insn_recorder #(.TCYC_W(TCYC_W), .REGS_W(REGS_W)) dut (
      .clk(clk), .reset(reset),
      .cpu_m1_start(cpu_m1_start), .cpu_mcycle_start(cpu_mcycle_start),
      .cpu_mcycle_type(cpu_mcycle_type), .cpu_fetch_valid(cpu_fetch_valid),
      .cpu_fetch_data(cpu_fetch_data), .cpu_mem_wr(cpu_mem_wr),
      .cpu_mem_waddr(cpu_mem_waddr), .cpu_mem_wdata(cpu_mem_wdata),
      .cpu_regs(cpu_regs),
`ifdef Z80FI_RECORD_MEM_RD_EN
      .cpu_mem_rd(cpu_mem_rd), .cpu_mem_raddr(cpu_mem_raddr), .cpu_mem_rdata(cpu_mem_rdata),
      .z80fi_mem_rd(z80fi_mem_rd), .z80fi_bus_raddr(z80fi_bus_raddr), .z80fi_bus_rdata(z80fi_bus_rdata),
`endif
      .z80fi_valid(z80fi_valid), .z80fi_insn(z80fi_insn), .z80fi_insn_len(z80fi_insn_len),
      .z80fi_regs_in(z80fi_regs_in), .z80fi_regs_out(z80fi_regs_out),
      .z80fi_mem_wr(z80fi_mem_wr), .z80fi_bus_waddr(z80fi_bus_waddr),
      .z80fi_bus_wdata(z80fi_bus_wdata),
      .z80fi_mcycle_type1(z80fi_mcycle_type1), .z80fi_mcycle_type2(z80fi_mcycle_type2),
      .z80fi_mcycle_type3(z80fi_mcycle_type3),
      .z80fi_tcycles1(z80fi_tcycles1), .z80fi_tcycles2(z80fi_tcycles2),
      .z80fi_tcycles3(z80fi_tcycles3), .z80fi_overflow(z80fi_overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]       insn;
      logic [2:0]        len;
      logic [2:0]        t1, t2, t3;
      logic [TCYC_W-1:0] c1, c2, c3;
      logic              wr;
      logic [15:0]       wa;
      logic [7:0]        wd;
      logic              ovf;
      logic [REGS_W-1:0] rin, rout;
   } pkt_t;

   pkt_t sb[$];
   pkt_t mon_e;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Register file with a given IP; other registers fixed (HL=0x1234, B=0x5A)
   function automatic logic [REGS_W-1:0] mk(input logic [15:0] ip);
      return {ip, 16'hFFF0, 16'h1100, 16'h2200, 16'h0044, 16'h5A00, 16'h3300, 16'h1234};
   endfunction

   // Compare every strobed packet against the oldest queued expectation
   always @(negedge clk) begin
      if (z80fi_valid === 1'b1) begin
         checks++;
         assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_packet observed insn=%0h expected=no packet", z80fi_insn);
         end
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("insn",     128'(z80fi_insn),         128'(mon_e.insn));
            chk("len",      128'(z80fi_insn_len),     128'(mon_e.len));
            chk("type1",    128'(z80fi_mcycle_type1), 128'(mon_e.t1));
            chk("type2",    128'(z80fi_mcycle_type2), 128'(mon_e.t2));
            chk("type3",    128'(z80fi_mcycle_type3), 128'(mon_e.t3));
            chk("tcycles1", 128'(z80fi_tcycles1),     128'(mon_e.c1));
            chk("tcycles2", 128'(z80fi_tcycles2),     128'(mon_e.c2));
            chk("tcycles3", 128'(z80fi_tcycles3),     128'(mon_e.c3));
            chk("mem_wr",   128'(z80fi_mem_wr),       128'(mon_e.wr));
            if (mon_e.wr) begin
               chk("waddr", 128'(z80fi_bus_waddr), 128'(mon_e.wa));
               chk("wdata", 128'(z80fi_bus_wdata), 128'(mon_e.wd));
            end
            chk("overflow", 128'(z80fi_overflow),     128'(mon_e.ovf));
            chk("regs_in",  128'(z80fi_regs_in),      128'(mon_e.rin));
            chk("regs_out", 128'(z80fi_regs_out),     128'(mon_e.rout));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clk1(input logic m1, input logic ms, input logic [2:0] typ,
                       input logic fv, input logic [7:0] fd,
                       input logic wr, input logic [15:0] wa, input logic [7:0] wd);
      cpu_m1_start     = m1;
      cpu_mcycle_start = ms;
      cpu_mcycle_type  = typ;
      cpu_fetch_valid  = fv;
      cpu_fetch_data   = fd;
      cpu_mem_wr       = wr;
      cpu_mem_waddr    = wa;
      cpu_mem_wdata    = wd;
      tick();
      cpu_m1_start     = 1'b0;
      cpu_mcycle_start = 1'b0;
      cpu_fetch_valid  = 1'b0;
      cpu_mem_wr       = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) clk1(1'b0, 1'b0, `CYCLE_NONE, 1'b0, 8'h00, 1'b0, 16'h0, 8'h00);
   endtask

   task automatic m1_fetch(input logic [7:0] b, input int nt, input logic [REGS_W-1:0] regs);
      cpu_regs = regs;
      clk1(1'b1, 1'b1, `CYCLE_M1, 1'b1, b, 1'b0, 16'h0, 8'h00);
      idle(nt - 1);
   endtask

   // Non-M1 M-cycle: optional fetch on T1, optional write on T2
   task automatic cyc(input logic [2:0] typ, input int nt, input logic fv, input logic [7:0] fd,
                      input logic wr, input logic [15:0] wa, input logic [7:0] wd);
      clk1(1'b0, 1'b1, typ, fv, fd, 1'b0, 16'h0, 8'h00);
      clk1(1'b0, 1'b0, `CYCLE_NONE, 1'b0, 8'h00, wr, wa, wd);
      idle(nt - 2);
   endtask

   task automatic push(input logic [31:0] insn, input logic [2:0] len,
                       input logic [2:0] t1, input logic [2:0] t2, input logic [2:0] t3,
                       input int c1, input int c2, input int c3,
                       input logic wr, input logic [15:0] wa, input logic [7:0] wd,
                       input logic ovf, input logic [REGS_W-1:0] rin, input logic [REGS_W-1:0] rout);
      pkt_t p;
      p.insn = insn; p.len = len; p.t1 = t1; p.t2 = t2; p.t3 = t3;
      p.c1 = TCYC_W'(c1); p.c2 = TCYC_W'(c2); p.c3 = TCYC_W'(c3);
      p.wr = wr; p.wa = wa; p.wd = wd; p.ovf = ovf; p.rin = rin; p.rout = rout;
      sb.push_back(p);
   endtask

   initial begin
      reset = 1'b1;
      cpu_m1_start = 1'b0; cpu_mcycle_start = 1'b0; cpu_mcycle_type = `CYCLE_NONE;
      cpu_fetch_valid = 1'b0; cpu_fetch_data = 8'h00; cpu_mem_wr = 1'b0;
      cpu_mem_waddr = 16'h0; cpu_mem_wdata = 8'h00; cpu_regs = '0;
      repeat (3) tick();

      chk("rst_valid",    128'(z80fi_valid),        128'(1'b0));
      chk("rst_insn",     128'(z80fi_insn),         128'(32'h0));
      chk("rst_len",      128'(z80fi_insn_len),     128'(3'd0));
      chk("rst_type1",    128'(z80fi_mcycle_type1), 128'(`CYCLE_NONE));
      chk("rst_type2",    128'(z80fi_mcycle_type2), 128'(`CYCLE_NONE));
      chk("rst_type3",    128'(z80fi_mcycle_type3), 128'(`CYCLE_NONE));
      chk("rst_tcycles1", 128'(z80fi_tcycles1),     128'(5'd0));
      chk("rst_mem_wr",   128'(z80fi_mem_wr),       128'(1'b0));
      chk("rst_overflow", 128'(z80fi_overflow),     128'(1'b0));
      chk("rst_regs_out", 128'(z80fi_regs_out),     128'(0));

      reset = 1'b0;
      tick();
      // Activity before any M1 is ignored
      cyc(`CYCLE_RD_MEM, 3, 1'b1, 8'hAA, 1'b1, 16'hBEEF, 8'h77);

      // NOP; first M1 emits nothing
      m1_fetch(8'h00, 4, mk(16'h0100));
      chk("first_m1_no_pkt", 128'(z80fi_valid), 128'(1'b0));
      push(32'h00, 3'd1, `CYCLE_M1, `CYCLE_NONE, `CYCLE_NONE, 4, 0, 0,
           1'b0, 16'h0, 8'h00, 1'b0, mk(16'h0100), mk(16'h0101));

      // LD (HL),B
      m1_fetch(8'h70, 4, mk(16'h0101));
      cyc(`CYCLE_RDWR_MEM, 3, 1'b0, 8'h00, 1'b1, 16'h1234, 8'h5A);
      push(32'h70, 3'd1, `CYCLE_M1, `CYCLE_RDWR_MEM, `CYCLE_NONE, 4, 3, 0,
           1'b1, 16'h1234, 8'h5A, 1'b0, mk(16'h0101), mk(16'h0102));

      // DD CB 05 C6 plus a stray fifth byte
      m1_fetch(8'hDD, 4, mk(16'h0102));
      cyc(`CYCLE_M1, 4, 1'b1, 8'hCB, 1'b0, 16'h0, 8'h00);
      clk1(1'b0, 1'b1, `CYCLE_RD_MEM, 1'b1, 8'h05, 1'b0, 16'h0, 8'h00);
      clk1(1'b0, 1'b0, `CYCLE_NONE,   1'b1, 8'hC6, 1'b0, 16'h0, 8'h00);
      clk1(1'b0, 1'b0, `CYCLE_NONE,   1'b1, 8'h00, 1'b0, 16'h0, 8'h00);
      idle(2);
      push(32'hC605CBDD, 3'd4, `CYCLE_M1, `CYCLE_M1, `CYCLE_RD_MEM, 4, 4, 5,
           1'b0, 16'h0, 8'h00, 1'b1, mk(16'h0102), mk(16'h0106));

      // Four M-cycles: fourth is not recorded
      m1_fetch(8'h34, 4, mk(16'h0106));
      cyc(`CYCLE_RD_MEM, 3, 1'b0, 8'h00, 1'b0, 16'h0, 8'h00);
      cyc(`CYCLE_RDWR_MEM, 3, 1'b0, 8'h00, 1'b1, 16'h4000, 8'h99);
      cyc(`CYCLE_RD_MEM, 3, 1'b0, 8'h00, 1'b0, 16'h0, 8'h00);
      push(32'h34, 3'd1, `CYCLE_M1, `CYCLE_RD_MEM, `CYCLE_RDWR_MEM, 4, 3, 3,
           1'b1, 16'h4000, 8'h99, 1'b1, mk(16'h0106), mk(16'h0107));

      // Clean NOP: overflow cleared again
      m1_fetch(8'h00, 4, mk(16'h0107));
      push(32'h00, 3'd1, `CYCLE_M1, `CYCLE_NONE, `CYCLE_NONE, 4, 0, 0,
           1'b0, 16'h0, 8'h00, 1'b0, mk(16'h0107), mk(16'h0108));

      // Two writes: first wins
      m1_fetch(8'h77, 4, mk(16'h0108));
      cyc(`CYCLE_RDWR_MEM, 3, 1'b0, 8'h00, 1'b1, 16'h2000, 8'h11);
      cyc(`CYCLE_RDWR_MEM, 3, 1'b0, 8'h00, 1'b1, 16'h2001, 8'h22);
      push(32'h77, 3'd1, `CYCLE_M1, `CYCLE_RDWR_MEM, `CYCLE_RDWR_MEM, 4, 3, 3,
           1'b1, 16'h2000, 8'h11, 1'b1, mk(16'h0108), mk(16'h0109));

      // Long M1 saturates the T-state counter
      m1_fetch(8'h76, 40, mk(16'h0109));
      push(32'h76, 3'd1, `CYCLE_M1, `CYCLE_NONE, `CYCLE_NONE, 31, 0, 0,
           1'b0, 16'h0, 8'h00, 1'b1, mk(16'h0109), mk(16'h010A));

      // Reset mid-instruction after two M-cycles
      m1_fetch(8'h00, 4, mk(16'h010A));
      cyc(`CYCLE_RD_MEM, 2, 1'b0, 8'h00, 1'b0, 16'h0, 8'h00);
      reset = 1'b1;
      #1;
      chk("async_rst_insn",     128'(z80fi_insn),         128'(32'h0));
      chk("async_rst_tcycles1", 128'(z80fi_tcycles1),     128'(5'd0));
      chk("async_rst_type1",    128'(z80fi_mcycle_type1), 128'(`CYCLE_NONE));
      chk("async_rst_overflow", 128'(z80fi_overflow),     128'(1'b0));
      tick();
      tick();
      reset = 1'b0;
      tick();

      // LD A,n after reset: first M1 silent, second emits clean packet
      m1_fetch(8'h3E, 4, mk(16'h0200));
      cyc(`CYCLE_RD_MEM, 3, 1'b1, 8'h42, 1'b0, 16'h0, 8'h00);
      push(32'h423E, 3'd2, `CYCLE_M1, `CYCLE_RD_MEM, `CYCLE_NONE, 4, 3, 0,
           1'b0, 16'h0, 8'h00, 1'b0, mk(16'h0200), mk(16'h0202));
      m1_fetch(8'h00, 4, mk(16'h0202));
      idle(3);

      chk("pending_packets", 128'(sb.size()), 128'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/z80fi_insn_recorder.md
Name: z80fi_insn_recorder

Overview:
Upstream producer of the z80fi retirement packet consumed by every z80fi_insn_spec_* checker. Watches the core's per-clock bus/M-cycle activity and register snapshots, and splits the stream at M1 boundaries. On each instruction boundary it emits one packet for the previous instruction: insn bytes, length, M-cycle types, T-cycle counts, memory write, and register state in/out.

Parameters:
TCYC_W, 5, width of each per-M-cycle T-state counter (saturating)
REGS_W, 128, packed register snapshot width; layout {IP,SP,IX,IY,AF,BC,DE,HL}, 16 bits each, IP in MSBs

Ports:
clk  in  1  core clock; one clk = one T-state
reset  in  1  asynchronous, active-high
cpu_m1_start  in  1  first T-state of an opcode-fetch M1 that begins a new instruction
cpu_mcycle_start  in  1  first T-state of any M-cycle (asserted together with cpu_m1_start)
cpu_mcycle_type  in  3  `CYCLE_* code of the M-cycle starting this clk
cpu_fetch_valid  in  1  instruction/operand byte fetched this clk
cpu_fetch_data  in  8  fetched byte
cpu_mem_wr  in  1  memory write strobe (one clk per write)
cpu_mem_waddr  in  16  write address
cpu_mem_wdata  in  8  write data
cpu_regs  in  REGS_W  architectural registers, valid on cpu_m1_start clk
z80fi_valid  out  1  one-clk packet strobe
z80fi_insn  out  32  insn bytes, byte0 in [7:0], unused bytes 0
z80fi_insn_len  out  3  fetched byte count, 1..4
z80fi_regs_in  out  REGS_W  snapshot at the instruction's M1
z80fi_regs_out  out  REGS_W  snapshot at the next instruction's M1
z80fi_mem_wr  out  1  instruction performed a write
z80fi_bus_waddr  out  16  first write address
z80fi_bus_wdata  out  8  first write data
z80fi_mcycle_type1..3  out  3 each  types of M-cycles 1..3; `CYCLE_NONE if absent
z80fi_tcycles1..3  out  TCYC_W each  T-states in M-cycles 1..3; 0 if absent
z80fi_overflow  out  1  >4 bytes, >3 M-cycles, >1 write, or counter saturation

Behaviour:
- Reset: all outputs 0, except mcycle_type1..3 = `CYCLE_NONE; FSM -> IDLE; accumulators cleared. Async assert, sync deassert.
- FSM: IDLE -> RUN on first cpu_m1_start (no packet emitted). RUN -> RUN on each later cpu_m1_start (packet emitted). No other states; reset from any state -> IDLE, partial instruction discarded, no packet.
- Attribution: every event in a cpu_m1_start clk belongs to the NEW instruction. Accumulators restart that clk: byte0, mcycle idx 1, tcycles1 = 1.
- Emission: at the edge ending the cpu_m1_start clk, outputs load the completed accumulators; regs_out = cpu_regs of that clk; z80fi_valid = 1 for exactly that next clk; packet fields hold until the next packet.
- Latency: packet valid one clk after the next instruction's M1 start.
- Bytes: each cpu_fetch_valid writes byte[len] and increments len. 5th+ byte dropped, len stays 4, overflow set.
- M-cycles: cpu_mcycle_start advances index and records type; tcycles[idx] counts every clk while idx is current, saturating at 2^TCYC_W-1 (overflow set). 4th+ M-cycle: type/T-states not recorded, overflow set.
- Writes: first cpu_mem_wr latches addr/data, sets mem_wr; later writes ignored, overflow set.
- cpu_mcycle_start without cpu_m1_start in IDLE: ignored.

Optional Feature:
Z80FI_RECORD_MEM_RD_EN: adds inputs cpu_mem_rd (1), cpu_mem_raddr (16), cpu_mem_rdata (8) and outputs z80fi_mem_rd, z80fi_bus_raddr, z80fi_bus_rdata. First non-fetch read is latched with the same first-wins/overflow rules as writes. Without the macro these ports do not exist and read activity is unobserved.

Test Plan:
- Reset, then M1 fetch 0x00 (4 T), then M1 -> no packet after first M1; packet: insn=0x00, len=1, type1=`CYCLE_M1, tcycles1=4, type2=`CYCLE_NONE, mem_wr=0.
- LD (HL),B: fetch 0x70 (4 T), write 0x1234<-0x5A (3 T), next M1; HL=0x1234, B=0x5A -> insn=0x70, len=1, type2=`CYCLE_RDWR_MEM, tcycles2=3, mem_wr=1, waddr=0x1234, wdata=0x5A, regs_out.IP=regs_in.IP+1.
- Fetch DD CB 05 C6 then 0x00 byte mis-asserted -> insn=0xC605CBDD, len=4, overflow=1.
- 4 M-cycles in one instruction -> types1..3 recorded, overflow=1; next packet overflow=0.
- Two writes (0x2000<-0x11, 0x2001<-0x22) -> waddr=0x2000, wdata=0x11, overflow=1.
- Reset asserted mid-instruction after 2 M-cycles -> no packet; first M1 after release emits nothing, second M1 emits clean packet.
